// File: rtl/kalman_seq.sv
// kalman_seq -- frame-level sequencer for the Kalman tracking datapath.
//
// Takes one centroid measurement per video frame over a valid/ready
// handshake. It steps the predict/update pipeline one register stage per
// cycle using one-hot enables, then returns the filtered position with a
// single-cycle strobe. Frames with no detection run predict-only. After
// MISS_LIMIT consecutive misses the track is declared lost, and the next
// real detection re-initialises the filter.
//
// Optional feature: define KALMAN_SEQ_CLAMP_EN to saturate out_x/out_y into
// the active display area. When it is undefined, the low DISP_WIDTH bits of
// the datapath result pass through unchanged.
//
// Ports:
//   clk, aresetn              clock, asynchronous active-low reset
//   meas_valid/meas_ready     measurement handshake
//   meas_x, meas_y, meas_miss measured centroid, "no detection" flag
//   kf_z_x, kf_z_y            captured measurement, held for the datapath
//   kf_stage_en               one-hot datapath stage enable
//   kf_predict_only, kf_init  datapath mode controls for this frame
//   kf_x, kf_y                signed filtered position from the datapath
//   out_valid, out_x, out_y   result strobe and filtered position
//   track_lost                track declared lost
//   busy                      run in progress (RUN or DONE)
module kalman_seq #(
  parameter int DISP_WIDTH = 11,
  parameter int NUM_STAGES = 7,
  parameter int MISS_LIMIT = 15,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         meas_valid,
  output logic                         meas_ready,
  input  logic [DISP_WIDTH-1:0]        meas_x,
  input  logic [DISP_WIDTH-1:0]        meas_y,
  input  logic                         meas_miss,
  output logic [DISP_WIDTH-1:0]        kf_z_x,
  output logic [DISP_WIDTH-1:0]        kf_z_y,
  output logic [NUM_STAGES-1:0]        kf_stage_en,
  output logic                         kf_predict_only,
  output logic                         kf_init,
  input  logic signed [DISP_WIDTH:0]   kf_x,
  input  logic signed [DISP_WIDTH:0]   kf_y,
  output logic                         out_valid,
  output logic [DISP_WIDTH-1:0]        out_x,
  output logic [DISP_WIDTH-1:0]        out_y,
  output logic                         track_lost,
  output logic                         busy
);

  localparam int CW = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_STAGES - 1);
  localparam logic [7:0]    MLIM = 8'(MISS_LIMIT);

`ifdef KALMAN_SEQ_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      miss_cnt_q;
  logic            init_pend_q;
  logic            init_run_q;   // this run should pulse kf_init in stage 0
  logic            accept;

  // Saturates a signed datapath coordinate into [0, lim-1].
  function automatic logic [DISP_WIDTH-1:0] clamp(
    input logic signed [DISP_WIDTH:0] v, input int lim);
    if (v < 0)               clamp = '0;
    else if (int'(v) >= lim) clamp = DISP_WIDTH'(lim - 1);
    else                     clamp = v[DISP_WIDTH-1:0];
  endfunction

  assign accept = meas_valid && meas_ready;

  // NOTE: every output of this block is assigned a default first, so no
  // path through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    meas_ready  = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    kf_init     = 1'b0;
    kf_stage_en = '0;
    case (state_q)
      IDLE: begin
        meas_ready = 1'b1;
        if (meas_valid) state_d = RUN;
      end
      RUN: begin
        busy        = 1'b1;
        kf_stage_en = NUM_STAGES'(1) << cnt_q;
        kf_init     = init_run_q && (cnt_q == '0);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state is reset asynchronously. Because the enables are decoded
  // from state_q, pulling aresetn low during a run drops them at once.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before the edge.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q           <= '0;
      miss_cnt_q      <= '0;
      init_pend_q     <= 1'b1;
      init_run_q      <= 1'b0;
      track_lost      <= 1'b0;
      kf_z_x          <= '0;
      kf_z_y          <= '0;
      kf_predict_only <= 1'b0;
      out_x           <= '0;
      out_y           <= '0;
    end else begin
      if (accept) begin
        kf_z_x          <= meas_x;
        kf_z_y          <= meas_y;
        kf_predict_only <= meas_miss;
        cnt_q           <= '0;
        init_run_q      <= init_pend_q && !meas_miss;
        if (meas_miss) begin
          if (miss_cnt_q < MLIM) miss_cnt_q <= miss_cnt_q + 8'd1;
          // This miss brings the count up to (or keeps it at) the limit.
          if (miss_cnt_q >= MLIM - 8'd1) begin
            track_lost  <= 1'b1;
            init_pend_q <= 1'b1;
          end
        end else begin
          miss_cnt_q  <= '0;
          init_pend_q <= 1'b0;
          track_lost  <= 1'b0;
        end
      end

      if (state_q == RUN) begin
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        // Load the result registers as the run enters DONE, so they are
        // valid in the same cycle as the out_valid strobe.
        if (cnt_q == LAST) begin
          out_x <= CLAMP_EN ? clamp(kf_x, H_ACTIVE) : kf_x[DISP_WIDTH-1:0];
          out_y <= CLAMP_EN ? clamp(kf_y, V_ACTIVE) : kf_y[DISP_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_kalman_seq.sv
// Self-checking bench for kalman_seq: table-driven frames plus hand-written
// sequences for back-to-back acceptance and reset in the middle of a run.
module tb_kalman_seq;

  localparam int DW = 11;
  localparam int NS = 7;

  logic                 clk = 1'b0;
  logic                 aresetn;
  logic                 meas_valid;
  logic                 meas_ready;
  logic [DW-1:0]        meas_x, meas_y;
  logic                 meas_miss;
  logic [DW-1:0]        kf_z_x, kf_z_y;
  logic [NS-1:0]        kf_stage_en;
  logic                 kf_predict_only, kf_init;
  logic signed [DW:0]   kf_x, kf_y;
  logic                 out_valid;
  logic [DW-1:0]        out_x, out_y;
  logic                 track_lost, busy;

  int n_checks = 0;
  int n_fail   = 0;

  kalman_seq dut (
    .clk(clk), .aresetn(aresetn),
    .meas_valid(meas_valid), .meas_ready(meas_ready),
    .meas_x(meas_x), .meas_y(meas_y), .meas_miss(meas_miss),
    .kf_z_x(kf_z_x), .kf_z_y(kf_z_y),
    .kf_stage_en(kf_stage_en), .kf_predict_only(kf_predict_only),
    .kf_init(kf_init), .kf_x(kf_x), .kf_y(kf_y),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .track_lost(track_lost), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]      x, y;
    logic               miss;
    logic signed [DW:0] kx, ky;
    logic               exp_init, exp_lost;
    logic [DW-1:0]      ox, oy;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for meas_ready. A timeout counts as a failed comparison.
  task automatic wait_ready();
    int n = 0;
    while (!meas_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_timeout", int'(meas_ready), 1);
  endtask

  task automatic do_frame(input vec_t v, input string tag);
    wait_ready();
    meas_valid = 1'b1;
    meas_x = v.x; meas_y = v.y; meas_miss = v.miss;
    kf_x = v.kx;  kf_y = v.ky;
    tick();                       // accept edge T; now in cycle T+1
    meas_valid = 1'b0;
    meas_x = '0; meas_y = '0; meas_miss = 1'b0;
    for (int k = 0; k < NS; k++) begin
      check({tag, " stage_en"}, int'(kf_stage_en), 1 << k);
      check({tag, " kf_init"}, int'(kf_init), (k == 0) ? int'(v.exp_init) : 0);
      check({tag, " ready/valid in run"}, int'({meas_ready, out_valid, busy}), 1);
      check({tag, " predict_only"}, int'(kf_predict_only), int'(v.miss));
      tick();
    end
    // Cycle T+NS+1: DONE
    check({tag, " out_valid"}, int'(out_valid), 1);
    check({tag, " done stage_en"}, int'(kf_stage_en), 0);
    check({tag, " out_x"}, int'(out_x), int'(v.ox));
    check({tag, " out_y"}, int'(out_y), int'(v.oy));
    check({tag, " track_lost"}, int'(track_lost), int'(v.exp_lost));
    check({tag, " kf_z_x"}, int'(kf_z_x), int'(v.x));
    check({tag, " kf_z_y"}, int'(kf_z_y), int'(v.y));
    check({tag, " ready in done"}, int'(meas_ready), 0);
    tick();
    check({tag, " ready after"}, int'({meas_ready, out_valid, busy}), 4);
  endtask

  initial begin
    int last_acc;
    int n_acc;
    vec_t rv;

    // ---- stimulus table ----
    vecs[0] = '{x:100, y:200, miss:0, kx:150, ky:250, exp_init:1, exp_lost:0, ox:150, oy:250};
    vecs[1] = '{x:101, y:201, miss:0, kx:151, ky:251, exp_init:0, exp_lost:0, ox:151, oy:251};
    for (int i = 0; i < 15; i++)
      vecs[2+i] = '{x:DW'(i), y:DW'(2*i), miss:1, kx:12'(300+i), ky:200,
                    exp_init:0, exp_lost:(i == 14), ox:DW'(300+i), oy:200};
    vecs[17] = '{x:7, y:8, miss:1, kx:310, ky:210, exp_init:0, exp_lost:1, ox:310, oy:210};
    vecs[18] = '{x:50, y:60, miss:0, kx:55, ky:66, exp_init:1, exp_lost:0, ox:55, oy:66};
`ifdef KALMAN_SEQ_CLAMP_EN
    vecs[19] = '{x:10, y:10, miss:0, kx:-5,  ky:700, exp_init:0, exp_lost:0, ox:0,   oy:479};
    vecs[20] = '{x:20, y:20, miss:0, kx:640, ky:480, exp_init:0, exp_lost:0, ox:639, oy:479};
`else
    vecs[19] = '{x:10, y:10, miss:0, kx:-5,  ky:700, exp_init:0, exp_lost:0, ox:2043, oy:700};
    vecs[20] = '{x:20, y:20, miss:0, kx:640, ky:480, exp_init:0, exp_lost:0, ox:640, oy:480};
`endif
    vecs[21] = '{x:30, y:30, miss:0, kx:639, ky:0, exp_init:0, exp_lost:0, ox:639, oy:0};

    // ---- reset ----
    aresetn = 1'b0; meas_valid = 1'b0; meas_x = '0; meas_y = '0;
    meas_miss = 1'b0; kf_x = '0; kf_y = '0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    tick();
    check("reset meas_ready", int'(meas_ready), 1);
    check("reset outputs", int'({out_valid, kf_init, kf_predict_only, track_lost, busy}), 0);
    check("reset stage_en", int'(kf_stage_en), 0);
    check("reset out_xy", int'({out_x, out_y}), 0);
    check("reset kf_z", int'({kf_z_x, kf_z_y}), 0);

    // ---- table-driven frames ----
    for (int i = 0; i < 22; i++)
      do_frame(vecs[i], $sformatf("vec%0d", i));

    // ---- meas_valid held high: one accept every NS+2 cycles ----
    meas_valid = 1'b1; meas_miss = 1'b0; meas_x = 5; meas_y = 6;
    kf_x = 12; kf_y = 13;
    last_acc = -1; n_acc = 0;
    for (int c = 0; c < 40; c++) begin
      check("ready while busy", int'(meas_ready & busy), 0);
      if (meas_ready) begin
        if (last_acc >= 0) check("accept interval", c - last_acc, NS + 2);
        last_acc = c;
        n_acc++;
      end
      tick();
    end
    check("accept count", n_acc, 5);
    meas_valid = 1'b0;
    repeat (12) tick();

    // ---- reset during stage 3 ----
    wait_ready();
    meas_valid = 1'b1; meas_x = 77; meas_y = 88; meas_miss = 1'b0;
    tick();
    meas_valid = 1'b0;
    repeat (3) tick();
    check("pre-reset stage_en", int'(kf_stage_en), 8);
    aresetn = 1'b0;
    #1;
    check("abort stage_en", int'(kf_stage_en), 0);
    check("abort busy/valid", int'({busy, out_valid}), 0);
    tick();
    aresetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      check("no out_valid after abort", int'(out_valid), 0);
      tick();
    end
    rv = '{x:200, y:100, miss:0, kx:210, ky:110, exp_init:1, exp_lost:0, ox:210, oy:110};
    do_frame(rv, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kalman_seq.md
# kalman_seq

Frame-level sequencer for the Kalman tracking datapath.
- Accepts one centroid measurement per video frame over a valid/ready handshake.
- Steps the multi-stage predict/update pipeline one stage per cycle with one-hot stage enables.
- Handles frames with no detection (predict-only) and declares loss of track after repeated misses, re-initialising the filter on reacquisition.
- Sits between the object-detection centroid output and the overlay/display logic.

## Interface
- DISP_WIDTH, 11, width of pixel coordinates
- NUM_STAGES, 7, number of datapath register stages sequenced per frame (≥2)
- MISS_LIMIT, 15, consecutive missed frames before track_lost (1..255)
- H_ACTIVE, 640, active horizontal pixels (clamp bound)
- V_ACTIVE, 480, active vertical pixels (clamp bound)

Ports:
- clk  in  1  clock
- aresetn  in  1  reset; asynchronous, active-low
- meas_valid  in  1  measurement offered
- meas_ready  out  1  sequencer can accept
- meas_x  in  DISP_WIDTH  measured x
- meas_y  in  DISP_WIDTH  measured y
- meas_miss  in  1  no detection this frame; qualified by meas_valid
- kf_z_x  out  DISP_WIDTH  registered measurement x to datapath
- kf_z_y  out  DISP_WIDTH  registered measurement y to datapath
- kf_stage_en  out  NUM_STAGES  one-hot stage enable
- kf_predict_only  out  1  datapath bypasses gain/innovation this frame
- kf_init  out  1  datapath reloads initial state/covariance
- kf_x  in  DISP_WIDTH+1  filtered x from datapath, signed two's complement
- kf_y  in  DISP_WIDTH+1  filtered y from datapath, signed two's complement
- out_valid  out  1  single-cycle result strobe
- out_x  out  DISP_WIDTH  filtered x
- out_y  out  DISP_WIDTH  filtered y
- track_lost  out  1  track declared lost
- busy  out  1  high in RUN or DONE

## Operation
- States:
  - IDLE: meas_ready=1.
  - RUN: stage counter cnt runs 0..NUM_STAGES-1.
  - DONE: single cycle.
- IDLE → RUN on meas_valid&meas_ready. At that edge:
  - Capture meas_x/meas_y into kf_z_x/kf_z_y (held until next accept).
  - Capture meas_miss into kf_predict_only (held for the whole run).
  - Set cnt=0.
- RUN:
  - kf_stage_en = 1<<cnt; cnt increments each cycle.
  - When cnt==NUM_STAGES-1, go to DONE.
  - meas_ready=0; meas_valid is ignored.
- DONE:
  - kf_stage_en=0.
  - Register kf_x/kf_y into out_x/out_y.
  - out_valid=1 for this one cycle.
  - Go to IDLE.
- Miss counter miss_cnt (8-bit, saturating at MISS_LIMIT):
  - Accepted miss: miss_cnt+1. track_lost sets when miss_cnt reaches MISS_LIMIT.
  - Accepted non-miss: miss_cnt=0.
- Init flag init_pend:
  - Set out of reset and whenever track_lost sets.
  - The first accepted non-miss measurement with init_pend=1 asserts kf_init during the stage-0 cycle only. That acceptance also clears init_pend and track_lost.
- Accepted miss while init_pend=1:
  - Run proceeds with kf_predict_only=1 and kf_init=0.
  - out_valid still pulses; output equals the datapath's current value.
- Simultaneous meas_valid and DONE: not accepted (meas_ready=0); accepted on the following IDLE cycle.

## Timing
- Accept at edge T:
  - Stage k enabled in cycle T+1+k.
  - out_valid in cycle T+NUM_STAGES+1.
  - meas_ready high from cycle T+NUM_STAGES+2.
- Throughput: one measurement per NUM_STAGES+2 cycles.
- Reset values:
  - meas_ready=1 after reset release.
  - All other outputs 0, except track_lost=0 with init_pend=1.
  - State=IDLE, cnt=0, miss_cnt=0.
- Reset mid-RUN aborts immediately: kf_stage_en=0, no out_valid. The next accepted non-miss measurement asserts kf_init.
- Coordinate widths: kf_x/kf_y are DISP_WIDTH+1 signed; out_x/out_y are DISP_WIDTH unsigned.

## Configuration
- KALMAN_SEQ_CLAMP_EN defined: out_x/out_y are saturated.
  - Negative → 0.
  - x ≥ H_ACTIVE → H_ACTIVE-1.
  - y ≥ V_ACTIVE → V_ACTIVE-1.
- Undefined: out_x/out_y = kf_x/kf_y[DISP_WIDTH-1:0], unclamped.

## Test plan
- Reset release, then meas (100,200), miss=0 → kf_init high only in stage-0 cycle; kf_stage_en walks 1,2,4..64; out_valid at accept+8 with out = datapath kf_x/kf_y.
- meas_valid held high continuously → accepts exactly every 9 cycles with NUM_STAGES=7; no overlapping runs; meas_ready low during busy.
- 15 consecutive misses → kf_predict_only=1 each run; track_lost rises after the 15th acceptance; the next non-miss asserts kf_init and clears track_lost.
- aresetn low at stage 3 → stage enables drop at once, no out_valid; next non-miss measurement asserts kf_init.
- With KALMAN_SEQ_CLAMP_EN: kf_x=-5, kf_y=700 → out (0,479). Without the macro: out_x=2043, out_y=700.
